// File: rtl/exe_pkg.sv
// Shared opcode constants and state encoding for the execute stage.
// Imported by exe_alu and exe_md_unit.
package exe_pkg;

    // ALU opcodes
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // Multiply/divide operation select
    localparam logic [2:0] MDOP_ALU  = 3'b000;
    localparam logic [2:0] MDOP_MULU = 3'b001;
    localparam logic [2:0] MDOP_DIVU = 3'b010;
    localparam logic [2:0] MDOP_MFHI = 3'b011;
    localparam logic [2:0] MDOP_MFLO = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } md_state_e;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU for the execute stage.
// Bit 3 of the opcode only matters for the shift group.
module exe_alu
    import exe_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [SHW-1:0] sa;
    assign sa = a[SHW-1:0];

    always_comb begin
        y = '0;
        casez (aluc)
            4'b?000:  y = a + b;
            4'b?100:  y = a - b;
            4'b?001:  y = a & b;
            4'b?101:  y = a | b;
            4'b?010:  y = a ^ b;
            4'b?110:  y = b << (WIDTH / 2);
            ALUC_SLL: y = b << sa;
            ALUC_SRL: y = b >> sa;
            ALUC_SRA: y = $signed(b) >>> sa;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/exe_md_unit.sv
// Execute stage: operand select + registered ALU result, plus iterative unsigned
// multiply/divide (one bit per cycle) updating HI/LO only on completion.
module exe_md_unit
    import exe_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ealuc,
    input  logic             eshift,
    input  logic             ealuimm,
    input  logic [2:0]       emdop,
    input  logic [WIDTH-1:0] eqa,
    input  logic [WIDTH-1:0] eqb,
    input  logic [WIDTH-1:0] eimm,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy
);

    localparam logic [SHW:0] CntInit = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CntOne  = (SHW + 1)'(1);

    md_state_e          state_q, state_d;
    logic [SHW:0]       count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   alu_a, alu_b, alu_y;
    logic               accept;

    assign alu_a = eshift ? (eimm >> 6) : eqa;
    assign alu_b = ealuimm ? eimm : eqb;

    exe_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .aluc (ealuc),
        .a    (alu_a),
        .b    (alu_b),
        .y    (alu_y)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; a zero divisor yields all-ones / dividend.
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = div_part >= {1'b0, opb_q};
    assign div_diff = div_part - {1'b0, opb_q};
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

    assign in_ready = (state_q == IDLE);
    assign md_busy  = ~in_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (emdop)
                        MDOP_MULU, MDOP_DIVU: begin
                            state_d = (emdop == MDOP_MULU) ? MUL : DIV;
                            count_d = CntInit;
                            acc_d   = {{WIDTH{1'b0}}, eqa};
                            opb_d   = eqb;
                        end
                        MDOP_MFHI: begin
                            result_d    = hi_q;
                            out_valid_d = 1'b1;
                        end
                        MDOP_MFLO: begin
                            result_d    = lo_q;
                            out_valid_d = 1'b1;
                        end
                        default: begin
                            result_d    = alu_y;
                            out_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL, DIV: begin
                acc_d   = (state_q == MUL) ? mul_next : div_next;
                count_d = count_q - CntOne;
                if (count_q == CntOne) begin
                    state_d = IDLE;
                    hi_d    = acc_d[2*WIDTH-1:WIDTH];
                    lo_d    = acc_d[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_exe_md_unit.sv
// Self-checking bench for exe_md_unit (WIDTH=32) against a plain-arithmetic reference model.
module tb_exe_md_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ealuc;
    logic          eshift;
    logic          ealuimm;
    logic [2:0]    emdop;
    logic [W-1:0]  eqa, eqb, eimm;
    logic          out_valid;
    logic [W-1:0]  result, hi, lo;
    logic          md_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_md_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ealuc     (ealuc),
        .eshift    (eshift),
        .ealuimm   (ealuimm),
        .emdop     (emdop),
        .eqa       (eqa),
        .eqb       (eqb),
        .eimm      (eimm),
        .out_valid (out_valid),
        .result    (result),
        .hi        (hi),
        .lo        (lo),
        .md_busy   (md_busy)
    );

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [63:0] ext;
        int          sa;
        sa = int'(a % 32);
        case (op)
            4'b0000, 4'b1000: return a + b;
            4'b0100, 4'b1100: return a + ~b + 32'd1;
            4'b0001, 4'b1001: return a & b;
            4'b0101, 4'b1101: return a | b;
            4'b0010, 4'b1010: return a ^ b;
            4'b0110, 4'b1110: return b * 32'd65536;
            4'b0011:          return W'(64'(b) * (64'd1 << sa));
            4'b0111:          return b / (32'd1 << sa);
            4'b1111: begin
                ext = {{32{b[31]}}, b};
                ext = ext >> sa;
                return ext[31:0];
            end
            default:          return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_operand_a(input logic sh, input logic [W-1:0] qa,
                                                   input logic [W-1:0] imm);
        return sh ? imm / 32'd64 : qa;
    endfunction

    task automatic set_inputs(input logic [2:0] mdop, input logic [3:0] aluc, input logic sh,
                              input logic isel, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] imm);
        emdop = mdop; ealuc = aluc; eshift = sh; ealuimm = isel;
        eqa = a; eqb = b; eimm = imm;
    endtask

    // Present one op at the negedge; returns #1 after the accepting posedge with in_valid low.
    task automatic issue(input logic [2:0] mdop, input logic [3:0] aluc, input logic sh,
                         input logic isel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm);
        @(negedge clk);
        set_inputs(mdop, aluc, sh, isel, a, b, imm);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles until in_ready returns; flags any HI/LO change or out_valid while busy.
    task automatic wait_idle(output int cycles, output logic hilo_moved, output logic ov_seen);
        logic [W-1:0] h0, l0;
        h0 = hi; l0 = lo;
        cycles = 0; hilo_moved = 1'b0; ov_seen = 1'b0;
        while (!in_ready && cycles < 100) begin
            if (hi !== h0 || lo !== l0) hilo_moved = 1'b1;
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        in_valid = 1'b0;
        set_inputs(3'b000, 4'b0000, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, md_busy, out_valid} !== 3'b100 || result !== 0 || hi !== 0 || lo !== 0) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b ov=%b res=%h hi=%h lo=%h, want 1 0 0 0 0 0",
                     in_ready, md_busy, out_valid, result, hi, lo);
        end
    endtask

    task automatic test_alu_directed;
        issue(3'b000, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, '0);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL add_wrap: ov=%b res=%h, want 1 00000000", out_valid, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL ov_pulse: ov=%b res=%h, want 0 00000000", out_valid, result);
        end
        issue(3'b000, 4'b0100, 1'b0, 1'b0, 32'h0, 32'h1, '0);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sub_wrap: ov=%b res=%h, want 1 ffffffff", out_valid, result);
        end
        issue(3'b000, 4'b1111, 1'b1, 1'b0, 32'h1234_5678, 32'h8000_0000, 32'h0000_0100);
        checks++;
        if (result !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra4: res=%h, want f8000000", result);
        end
        issue(3'b000, 4'b0011, 1'b1, 1'b0, 32'h0, 32'h1, 32'h0000_07C0);
        checks++;
        if (result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sll31: res=%h, want 80000000", result);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b, imm, exp;
        logic [3:0]   op;
        logic         sh, isel;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; imm = $urandom;
            op = 4'($urandom_range(0, 15)); sh = 1'($urandom); isel = 1'($urandom);
            set_inputs(3'b000, op, sh, isel, a, b, imm);
            in_valid = 1'b1;
            exp = ref_alu(op, ref_operand_a(sh, a, imm), isel ? imm : b);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== exp) begin
                errors++;
                $display("FAIL b2b[%0d] op=%b: ov=%b res=%h, want 1 %h", i, op, out_valid,
                         result, exp);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_alu_random;
        logic [W-1:0] a, b, imm, exp;
        logic [3:0]   op;
        logic [2:0]   md;
        logic         sh, isel;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; imm = $urandom;
            if (i % 4 == 0) b = 32'h8000_0000 | b;
            op = 4'($urandom_range(0, 15)); sh = 1'($urandom); isel = 1'($urandom);
            case ($urandom_range(0, 3))
                0: md = 3'b000;
                1: md = 3'b101;
                2: md = 3'b110;
                default: md = 3'b111;
            endcase
            exp = ref_alu(op, ref_operand_a(sh, a, imm), isel ? imm : b);
            issue(md, op, sh, isel, a, b, imm);
            checks++;
            if (out_valid !== 1'b1 || result !== exp) begin
                errors++;
                $display("FAIL alu_rand[%0d] md=%b op=%b: ov=%b res=%h, want 1 %h", i, md, op,
                         out_valid, result, exp);
            end
        end
    endtask

    task automatic test_mulu_max_mfhi;
        int k;
        logic moved, ov_busy;
        moved = 1'b0; ov_busy = 1'b0;
        issue(3'b001, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
        // Upstream presents MFHI immediately and holds it while the unit is busy.
        set_inputs(3'b011, 4'b0000, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            if (hi !== 0 || lo !== 0) moved = 1'b1;
            if (out_valid) ov_busy = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != W || moved || ov_busy) begin
            errors++;
            $display("FAIL mulu_busy: cycles=%0d moved=%b ov=%b, want %0d 0 0", k, moved,
                     ov_busy, W);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mulu_max: hi=%h lo=%h ov=%b, want fffffffe 00000001 0", hi, lo,
                     out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mfhi_after: ov=%b res=%h, want 1 fffffffe", out_valid, result);
        end
    endtask

    task automatic test_reset_mid_mul;
        issue(3'b001, 4'b0000, 1'b0, 1'b0, 32'd3, 32'd5, '0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (hi !== 0 || lo !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_mul: hi=%h lo=%h rdy=%b ov=%b, want 0 0 1 0", hi, lo,
                     in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || md_busy !== 1'b0 || hi !== 0 || lo !== 0) begin
            errors++;
            $display("FAIL rst_after: rdy=%b busy=%b hi=%h lo=%h, want 1 0 0 0", in_ready,
                     md_busy, hi, lo);
        end
    endtask

    task automatic test_divu;
        int k;
        logic moved, ov_busy;
        issue(3'b010, 4'b0000, 1'b0, 1'b0, 32'd100, 32'd7, '0);
        // Operand changes after accept must not affect the running division.
        set_inputs(3'b010, 4'b0000, 1'b0, 1'b0, 32'd9, 32'd2, '0);
        wait_idle(k, moved, ov_busy);
        checks++;
        if (k != W || moved || ov_busy || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL divu_100_7: cyc=%0d mv=%b ov=%b lo=%0d hi=%0d, want %0d 0 0 14 2", k,
                     moved, ov_busy, lo, hi, W);
        end
        issue(3'b010, 4'b0000, 1'b0, 1'b0, 32'd5, 32'd0, '0);
        wait_idle(k, moved, ov_busy);
        checks++;
        if (k != W || lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
            errors++;
            $display("FAIL divu_by0: cyc=%0d lo=%h hi=%h, want %0d ffffffff 00000005", k, lo, hi,
                     W);
        end
    endtask

    task automatic test_md_random;
        int k;
        logic moved, ov_busy, is_mul;
        logic [W-1:0] a, b, exp_hi, exp_lo;
        logic [63:0]  p;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            if (i == 3) b = b >> 20;
            is_mul = (i % 2 == 0);
            if (is_mul) begin
                p = 64'(a) * 64'(b);
                exp_hi = p[63:32]; exp_lo = p[31:0];
            end else begin
                exp_lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
                exp_hi = (b == 0) ? a : a % b;
            end
            issue(is_mul ? 3'b001 : 3'b010, 4'b0000, 1'b0, 1'b0, a, b, '0);
            wait_idle(k, moved, ov_busy);
            checks++;
            if (k != W || hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("FAIL md_rand[%0d] mul=%b a=%h b=%h: cyc=%0d hi=%h lo=%h, want %0d %h %h",
                         i, is_mul, a, b, k, hi, lo, W, exp_hi, exp_lo);
            end
            issue(3'b100, 4'b0000, 1'b0, 1'b0, '0, '0, '0);
            checks++;
            if (out_valid !== 1'b1 || result !== exp_lo) begin
                errors++;
                $display("FAIL mflo[%0d]: ov=%b res=%h, want 1 %h", i, out_valid, result, exp_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_back_to_back();
        test_alu_random();
        test_mulu_max_mfhi();
        test_reset_mid_mul();
        test_divu();
        test_md_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
